// File: rtl/pa_fpu.sv
// Shared types and register-map helpers for the FPU host front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pa_fpu;

    typedef enum logic [7:0] {
        op_add  = 8'h00,
        op_sub  = 8'h01,
        op_mul  = 8'h02,
        op_div  = 8'h03,
        op_sqrt = 8'h04,
        op_cmp  = 8'h05
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Status register bit positions; core flags occupy [ST_FLAGS +: 4].
    localparam int ST_BUSY  = 0;
    localparam int ST_END   = 1;
    localparam int ST_ERR   = 2;
    localparam int ST_TO    = 3;
    localparam int ST_FLAGS = 4;

    // Command register sits right after the last operand lane.
    function automatic int cmd_addr(int n_ops, int bpo);
        return n_ops * bpo;
    endfunction

    function automatic int status_addr(int n_ops, int bpo);
        return cmd_addr(n_ops, bpo) + 1;
    endfunction

    function automatic int result_addr(int n_ops, int bpo, int lane);
        return cmd_addr(n_ops, bpo) + 2 + lane;
    endfunction

endpackage

// File: rtl/fpu_host_if.sv
// Host register window (operands, command, status, result) plus command handshake to the FPU core.
// Latency: write strobe edge n -> register update / start_o after n+1; read data registered one edge.
// Backpressure: none on the host bus; writes while busy are dropped and flagged in the sticky err bit.
module fpu_host_if
    import pa_fpu::*;
#(
    parameter int DATA_W  = 8,
    parameter int OP_W    = 32,
    parameter int N_OPS   = 2,
    parameter int ADDR_W  = 6,
    parameter int TIMEOUT = 1023
) (
    input  logic                    clk,
    input  logic                    arst_n,
    input  logic [DATA_W-1:0]       databus_in,
    output logic [DATA_W-1:0]       databus_out,
    input  logic [ADDR_W-1:0]       addr,
    input  logic                    cs,
    input  logic                    rd,
    input  logic                    wr,
    input  logic                    end_ack,
    output logic                    cmd_end,
    output logic                    busy,
    output logic [N_OPS*OP_W-1:0]   operands_o,
    output logic [DATA_W-1:0]       opcode_o,
    output logic                    start_o,
    input  logic                    core_done_i,
    input  logic [OP_W-1:0]         result_i,
    input  logic [3:0]              core_flags_i
);

    localparam int BPO  = OP_W / DATA_W;
    localparam int CMD  = cmd_addr(N_OPS, BPO);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    localparam logic [ADDR_W-1:0] A_CMD  = ADDR_W'(CMD);
    localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(status_addr(N_OPS, BPO));
    localparam logic [WD_W-1:0]   WD_TOP = WD_W'(TIMEOUT);

    // Captured host write (one per strobe), processed one edge after it is sampled.
    logic                strobe_prev;
    logic                wr_evt;
    logic [ADDR_W-1:0]   waddr;
    logic [DATA_W-1:0]   wdata;

    state_e              state_q, state_d;
    logic [N_OPS*OP_W-1:0] ops_q;
    logic [DATA_W-1:0]   opcode_q;
    logic [OP_W-1:0]     result_q;
    logic [3:0]          flags_q;
    logic                err_q;
    logic                to_q;
    logic [WD_W-1:0]     wd_q;

    logic                busy_w;
    logic                cmd_wr;
    logic                cmd_go;
    logic                ld_result;
    logic                set_to;
    logic [DATA_W-1:0]   status_w;
    logic [DATA_W-1:0]   rdata;

    assign busy_w     = (state_q == START) || (state_q == WAIT);
    assign cmd_wr     = wr_evt && (waddr == A_CMD);
    assign busy       = busy_w;
    assign start_o    = (state_q == START);
    assign cmd_end    = (state_q == DONE);
    assign operands_o = ops_q;
    assign opcode_o   = opcode_q;

    // Falling-edge detect on the combined cs|wr strobe, with address/data captured alongside.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            strobe_prev <= 1'b1;
            wr_evt      <= 1'b0;
            waddr       <= '0;
            wdata       <= '0;
        end else begin
            strobe_prev <= cs | wr;
            wr_evt      <= ~cs & ~wr & strobe_prev;
            waddr       <= addr;
            wdata       <= databus_in;
        end
    end

    // Command FSM state register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; done beats the watchdog, and a command write in DONE beats end_ack.
    always_comb begin
        state_d   = state_q;
        cmd_go    = 1'b0;
        ld_result = 1'b0;
        set_to    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_wr) begin
                    cmd_go  = 1'b1;
                    state_d = START;
                end
            end
            START: state_d = WAIT;
            WAIT: begin
                if (core_done_i) begin
                    ld_result = 1'b1;
                    state_d   = DONE;
                end else if (wd_q == WD_TOP) begin
                    set_to  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (cmd_wr) begin
                    cmd_go  = 1'b1;
                    state_d = START;
                end else if (end_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Register file, sticky error/timeout bits, result latch and saturating watchdog.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ops_q    <= '0;
            opcode_q <= '0;
            result_q <= '0;
            flags_q  <= '0;
            err_q    <= 1'b0;
            to_q     <= 1'b0;
            wd_q     <= '0;
        end else begin
            if (wr_evt && busy_w) begin
                err_q <= 1'b1;
            end else if (cmd_go) begin
                err_q <= 1'b0;
            end
            for (int i = 0; i < CMD; i++) begin
                if (wr_evt && !busy_w && (waddr == ADDR_W'(i))) begin
                    ops_q[i*DATA_W +: DATA_W] <= wdata;
                end
            end
            if (cmd_go) begin
                opcode_q <= wdata;
            end
            if (state_q == START) begin
                wd_q <= '0;
            end else if ((state_q == WAIT) && (wd_q != WD_TOP)) begin
                wd_q <= wd_q + WD_W'(1);
            end
            if (cmd_go) begin
                to_q <= 1'b0;
            end else if (set_to) begin
                to_q <= 1'b1;
            end
            if (ld_result) begin
                result_q <= result_i;
                flags_q  <= core_flags_i;
            end else if (set_to) begin
                result_q <= '0;
            end
        end
    end

    // Status word as seen by the host.
    always_comb begin
        status_w                  = '0;
        status_w[ST_BUSY]         = busy_w;
        status_w[ST_END]          = (state_q == DONE);
        status_w[ST_ERR]          = err_q;
        status_w[ST_TO]           = to_q;
        status_w[ST_FLAGS +: 4]   = flags_q;
    end

    // Read mux over the register map; unmapped addresses return zero.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < CMD; i++) begin
            if (addr == ADDR_W'(i)) begin
                rdata = ops_q[i*DATA_W +: DATA_W];
            end
        end
        if (addr == A_CMD) begin
            rdata = opcode_q;
        end
        if (addr == A_STAT) begin
            rdata = status_w;
        end
        for (int j = 0; j < BPO; j++) begin
            if (addr == ADDR_W'(result_addr(N_OPS, BPO, j))) begin
                rdata = result_q[j*DATA_W +: DATA_W];
            end
        end
    end

    // Registered read data, zero whenever no read strobe is active.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            databus_out <= '0;
        end else begin
            databus_out <= (!cs && !rd) ? rdata : '0;
        end
    end

endmodule

// File: tb/tb_fpu_host_if.sv
// Randomized scoreboard bench for fpu_host_if with a register-level reference model.
// Latency: reads checked one edge after the strobe; command/done timing checked directly.
// Backpressure: n/a (host bus has none; core responses are modelled in the bench).
module tb_fpu_host_if;
    import pa_fpu::*;

    localparam int DW  = 8;
    localparam int OW  = 32;
    localparam int NO  = 2;
    localparam int AW  = 6;
    localparam int TO  = 20;
    localparam int BPO = OW / DW;
    localparam int CMD = NO * BPO;

    logic            clk;
    logic            arst_n;
    logic [DW-1:0]   databus_in;
    logic [DW-1:0]   databus_out;
    logic [AW-1:0]   addr;
    logic            cs, rd, wr;
    logic            end_ack;
    logic            cmd_end;
    logic            busy;
    logic [NO*OW-1:0] operands_o;
    logic [DW-1:0]   opcode_o;
    logic            start_o;
    logic            core_done_i;
    logic [OW-1:0]   result_i;
    logic [3:0]      core_flags_i;

    fpu_host_if #(.DATA_W(DW), .OP_W(OW), .N_OPS(NO), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .arst_n(arst_n), .databus_in(databus_in), .databus_out(databus_out),
        .addr(addr), .cs(cs), .rd(rd), .wr(wr), .end_ack(end_ack), .cmd_end(cmd_end),
        .busy(busy), .operands_o(operands_o), .opcode_o(opcode_o), .start_o(start_o),
        .core_done_i(core_done_i), .result_i(result_i), .core_flags_i(core_flags_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the register map as plain values.
    logic [31:0] m_ops [NO];
    logic [7:0]  m_opc;
    logic [31:0] m_res;
    logic [3:0]  m_fl;
    bit          m_err, m_to, m_busy, m_end;

    task automatic model_reset();
        for (int k = 0; k < NO; k++) m_ops[k] = '0;
        m_opc = '0; m_res = '0; m_fl = '0;
        m_err = 0; m_to = 0; m_busy = 0; m_end = 0;
    endtask

    function automatic logic [7:0] model_reg(input int a);
        if (a < CMD) return 8'(m_ops[a / BPO] >> (8 * (a % BPO)));
        if (a == CMD) return m_opc;
        if (a == CMD + 1) return {m_fl, m_to, m_err, m_end, m_busy};
        if (a >= CMD + 2 && a < CMD + 2 + BPO) return 8'(m_res >> (8 * (a - CMD - 2)));
        return 8'h00;
    endfunction

    // Core behaviour knobs.
    bit          core_mute;
    int          core_dly;
    logic [31:0] core_res;
    logic [3:0]  core_fl;

    // Scoreboard for host reads.
    logic [7:0] exp_q [$];
    bit         rd_hit = 0;

    always @(posedge clk) rd_hit = !cs && !rd;

    always @(negedge clk) begin
        if (rd_hit) begin
            if (exp_q.size() == 0) begin
                check("rd_underflow", 1, 0);
            end else begin
                check("rd_data", databus_out, exp_q.pop_front());
            end
        end
    end

    // Start pulse monitor.
    int n_start = 0;
    int st_dbl  = 0;
    bit st_prev = 0;
    always @(posedge clk) begin
        if (start_o === 1'b1) begin
            n_start++;
            if (st_prev) st_dbl++;
        end
        st_prev = (start_o === 1'b1);
    end

    // Core model: answers each start pulse after core_dly edges unless muted.
    initial begin
        forever begin
            @(posedge clk);
            if (start_o === 1'b1 && !core_mute) begin
                repeat (core_dly - 1) @(posedge clk);
                @(negedge clk);
                core_done_i  = 1'b1;
                result_i     = core_res;
                core_flags_i = core_fl;
                @(negedge clk);
                core_done_i  = 1'b0;
                result_i     = $urandom;
                core_flags_i = 4'($urandom);
                check("done_cmd_end", cmd_end, 1);
                check("done_busy", busy, 0);
            end
        end
    end

    task automatic host_write(input int a, input logic [7:0] d, input int hold);
        @(negedge clk);
        addr = AW'(a); databus_in = d; cs = 1'b0; wr = 1'b0;
        repeat (hold) @(negedge clk);
        cs = 1'b1; wr = 1'b1;
        if (m_busy) m_err = 1;
        else if (a < CMD) m_ops[a / BPO][8 * (a % BPO) +: 8] = d;
        else if (a == CMD) begin
            m_opc = d; m_err = 0; m_to = 0; m_busy = 1; m_end = 0;
        end
    endtask

    task automatic host_read(input int a);
        @(negedge clk);
        addr = AW'(a); cs = 1'b0; rd = 1'b0;
        exp_q.push_back(model_reg(a));
        @(negedge clk);
        cs = 1'b1; rd = 1'b1;
    endtask

    task automatic issue_cmd(input logic [7:0] op);
        int s0;
        s0 = n_start;
        host_write(CMD, op, 1);
        @(negedge clk);
        check("start_hi", start_o, 1);
        check("busy_hi", busy, 1);
        check("opcode", opcode_o, op);
        @(negedge clk);
        check("start_lo", start_o, 0);
        check("busy_wait", busy, 1);
        check("one_start", n_start, s0 + 1);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (cmd_end !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("cmd_end_seen", cmd_end, 1);
        check("busy_after_done", busy, 0);
        m_busy = 0; m_end = 1;
        if (!core_mute && core_dly <= TO + 1) begin
            m_res = core_res; m_fl = core_fl;
        end else begin
            m_to = 1; m_res = '0;
        end
    endtask

    task automatic ack();
        @(negedge clk); end_ack = 1'b1;
        @(negedge clk); end_ack = 1'b0;
        check("ack_cmd_end", cmd_end, 0);
        m_end = 0;
    endtask

    task automatic read_status_result();
        host_read(CMD + 1);
        for (int j = 0; j < BPO; j++) host_read(CMD + 2 + j);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n, s0;
        logic [31:0] va, vb;
        cs = 1; rd = 1; wr = 1; end_ack = 0; addr = '0; databus_in = '0;
        core_done_i = 0; result_i = '0; core_flags_i = '0;
        core_mute = 1; core_dly = 1; core_res = '0; core_fl = '0;
        model_reset();
        arst_n = 1'b0;
        repeat (3) @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);

        check("rst_operands", operands_o, 0);
        check("rst_opcode", opcode_o, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_end", cmd_end, 0);
        check("rst_start", start_o, 0);
        check("rst_dout", databus_out, 0);
        read_status_result();

        // Directed multiply from the reference scenario.
        va = 32'h43e0d666; vb = 32'h43a6ffdf;
        for (int j = 0; j < BPO; j++) host_write(j, va[8*j +: 8], 1);
        for (int j = 0; j < BPO; j++) host_write(BPO + j, vb[8*j +: 8], 1);
        @(negedge clk);
        check("operands_ab", operands_o, 64'h43a6ffdf_43e0d666);
        core_mute = 0; core_dly = 5; core_res = 32'h4812abc0; core_fl = 4'b0001;
        issue_cmd(op_mul);
        wait_done(n);
        read_status_result();
        ack();
        host_read(CMD + 1);

        // Write while busy is dropped and sets err; next command clears it.
        core_dly = 15; core_res = $urandom; core_fl = 4'h5;
        issue_cmd(op_add);
        host_write(0, 8'hff, 1);
        @(negedge clk);
        check("busy_write_dropped", operands_o, {m_ops[1], m_ops[0]});
        host_read(CMD + 1);
        wait_done(n);
        host_read(CMD + 1);
        core_res = $urandom; core_fl = 4'ha;
        issue_cmd(op_sub);
        host_read(CMD + 1);
        wait_done(n);
        ack();

        // Silent core: watchdog expires after TIMEOUT+1 cycles in WAIT.
        core_mute = 1;
        issue_cmd(op_div);
        wait_done(n);
        check("timeout_latency", n, TO + 1);
        read_status_result();
        ack();

        // Done on the watchdog's last edge wins.
        core_mute = 0; core_dly = TO + 1; core_res = $urandom; core_fl = 4'h3;
        issue_cmd(op_mul);
        wait_done(n);
        check("done_edge_latency", n, TO + 1);
        read_status_result();

        // end_ack and a command write on the same edge in DONE.
        core_dly = 3; core_res = $urandom; core_fl = 4'h6;
        s0 = n_start;
        @(negedge clk);
        addr = AW'(CMD); databus_in = op_add; cs = 0; wr = 0; end_ack = 1;
        @(negedge clk);
        cs = 1; wr = 1; end_ack = 0;
        m_opc = op_add; m_err = 0; m_to = 0; m_busy = 1; m_end = 0;
        check("same_edge_cmd_end", cmd_end, 0);
        @(negedge clk);
        check("same_edge_start", start_o, 1);
        @(negedge clk);
        check("same_edge_one_start", n_start, s0 + 1);
        wait_done(n);
        ack();

        // core_done_i outside WAIT is ignored.
        @(negedge clk);
        core_done_i = 1; result_i = 32'hdeadbeef; core_flags_i = 4'hf;
        @(negedge clk);
        core_done_i = 0;
        check("stray_done_cmd_end", cmd_end, 0);
        read_status_result();

        // Long write strobe produces a single write with the first data.
        @(negedge clk);
        addr = AW'(5); databus_in = 8'h5a; cs = 0; wr = 0;
        @(negedge clk);
        databus_in = 8'ha5;
        repeat (3) @(negedge clk);
        cs = 1; wr = 1;
        m_ops[1][15:8] = 8'h5a;
        @(negedge clk);
        check("held_write", operands_o, {m_ops[1], m_ops[0]});
        core_dly = 4; core_res = $urandom; core_fl = 4'h9;
        s0 = n_start;
        @(negedge clk);
        addr = AW'(CMD); databus_in = op_sqrt; cs = 0; wr = 0;
        repeat (4) @(negedge clk);
        cs = 1; wr = 1;
        m_opc = op_sqrt; m_err = 0; m_to = 0; m_busy = 1; m_end = 0;
        @(negedge clk); end_ack = 1;
        @(negedge clk); end_ack = 0;
        wait_done(n);
        check("held_cmd_one_start", n_start, s0 + 1);
        host_read(CMD + 1);
        ack();

        // Randomized traffic.
        for (int it = 0; it < 20; it++) begin
            for (int w = 0; w < int'($urandom_range(0, 4)); w++)
                host_write($urandom_range(0, CMD - 1), 8'($urandom), $urandom_range(1, 3));
            host_write($urandom_range(CMD + 1, 63), 8'($urandom), 1);
            @(negedge clk);
            check("rand_operands", operands_o, {m_ops[1], m_ops[0]});
            host_read($urandom_range(0, 63));
            host_read($urandom_range(CMD + 2 + BPO, 63));
            core_dly = $urandom_range(1, 12); core_res = $urandom; core_fl = 4'($urandom);
            issue_cmd(8'($urandom));
            wait_done(n);
            read_status_result();
            host_read(CMD);
            ack();
            host_read(CMD + 1);
        end

        // Reset in WAIT aborts everything.
        core_mute = 1;
        issue_cmd(op_mul);
        repeat (3) @(negedge clk);
        arst_n = 1'b0;
        @(negedge clk);
        check("arst_operands", operands_o, 0);
        check("arst_opcode", opcode_o, 0);
        check("arst_busy", busy, 0);
        check("arst_cmd_end", cmd_end, 0);
        check("arst_start", start_o, 0);
        check("arst_dout", databus_out, 0);
        s0 = n_start;
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        model_reset();
        repeat (TO + 10) @(negedge clk);
        check("arst_no_start", n_start, s0);
        check("arst_no_cmd_end", cmd_end, 0);
        read_status_result();

        repeat (2) @(negedge clk);
        check("start_single_cycle", st_dbl, 0);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
